ej32_mem8_resp: RTL and testbench

//  Responder end of the eJ32 8-bit memory bus: byte-wide single-port SRAM serving the

---
 rtl/ej32_mem8_resp.sv | 135 +++++++++++++
 tb/tb_ej32_mem8_resp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ej32_mem8_resp.sv
// eJ32 8-bit memory bus responder: byte SRAM with registered reads, an
// OBUF-window write snoop feeding a first-word-fall-through TX FIFO, and a
// host RX byte stream written into the TIB window as a ring.
module ej32_mem8_resp #(
  parameter int ASZ  = 17,
  parameter int TIB  = 'h1000,
  parameter int ISZ  = 'h400,
  parameter int OBUF = 'h1400,
  parameter int OSZ  = 'h400,
  parameter int FD   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ASZ-1:0] b8_ai,
  input  logic           b8_we,
  input  logic [7:0]     b8_vi,
  output logic [7:0]     b8_vo,
  output logic           busy,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           tx_ovf,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  output logic [ASZ-1:0] rx_ptr
);

  localparam int CW  = $clog2(OSZ);
  localparam int FAW = $clog2(FD);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ASZ-1:0] TIB_A  = ASZ'(TIB);
  localparam logic [ASZ-1:0] OBUF_A = ASZ'(OBUF);
  localparam logic [ASZ-1:0] OSZ_A  = ASZ'(OSZ);
  localparam logic [ASZ-1:0] IMSK_A = ASZ'(ISZ - 1);

  logic [7:0]     mem [2**ASZ];
  logic [7:0]     fifo [FD];

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic [FAW-1:0] wp, rp;
  logic [FAW:0]   fcnt;

  logic           run, full, empty, pop, snoop, push, drop, rx_take;
  logic [ASZ-1:0] obuf_off, rx_off, rx_ptr_nxt, clr_addr;

  assign run      = (state == ST_RUN);
  assign busy     = ~run;
  assign clr_addr = OBUF_A + ASZ'(cnt);

  // The OBUF window never wraps the address space, so one wrapped subtract
  // and compare decodes it.
  assign obuf_off = b8_ai - OBUF_A;
  assign full     = (fcnt == (FAW+1)'(FD));
  assign empty    = (fcnt == '0);
  assign pop      = ~empty & tx_ready;
  assign snoop    = run & b8_we & (obuf_off < OSZ_A);
  assign push     = snoop & (~full | pop);
  assign drop     = snoop & full & ~pop;

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo[rp];

  // Host bytes share the single write port; a CPU write always wins.
  assign rx_ready   = run & ~b8_we;
  assign rx_take    = rx_valid & rx_ready;
  assign rx_off     = rx_ptr - TIB_A + ASZ'(1);
  assign rx_ptr_nxt = TIB_A + (rx_off & IMSK_A);

  // SRAM write port: INIT sweep, else CPU write, else host RX byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)
        mem[clr_addr] <= 8'h00;
      else if (b8_we)
        mem[b8_ai] <= b8_vi;
      else if (rx_valid)
        mem[rx_ptr] <= rx_data;
    end
  end

  // Registered read port; holds across CPU writes, old data on RX collision.
  always_ff @(posedge clk) begin
    if (rst)
      b8_vo <= 8'h00;
    else if (!run)
      b8_vo <= 8'h00;
    else if (!b8_we)
      b8_vo <= mem[b8_ai];
  end

  // TX FIFO storage; on a full FIFO with a pop the slot under wp is the
  // one being read out this cycle, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (push)
      fifo[wp] <= b8_vi;
  end

  // Control: INIT/RUN sequencing, FIFO pointers, overflow flag, RX pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
      fcnt   <= '0;
      tx_ovf <= 1'b0;
      rx_ptr <= TIB_A;
    end else begin
      if (!run) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(OSZ - 1))
          state <= ST_RUN;
      end
      if (push)
        wp <= wp + FAW'(1);
      if (pop)
        rp <= rp + FAW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + (FAW+1)'(1);
        2'b01:   fcnt <= fcnt - (FAW+1)'(1);
        default: fcnt <= fcnt;
      endcase
      if (drop)
        tx_ovf <= 1'b1;
      if (rx_take)
        rx_ptr <= rx_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_ej32_mem8_resp.sv
// Bench for ej32_mem8_resp: directed scenarios plus randomized traffic,
// compared every cycle against a byte-map / queue reference model.
module tb_ej32_mem8_resp;

  localparam int ASZ  = 17;
  localparam int TIB  = 'h1000;
  localparam int ISZ  = 'h400;
  localparam int OBUF = 'h1400;
  localparam int OSZ  = 'h400;
  localparam int FD   = 16;
  localparam int MASK = (1 << ASZ) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [ASZ-1:0] b8_ai;
  logic           b8_we;
  logic [7:0]     b8_vi;
  logic [7:0]     b8_vo;
  logic           busy;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           tx_ovf;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [ASZ-1:0] rx_ptr;

  ej32_mem8_resp #(
    .ASZ(ASZ), .TIB(TIB), .ISZ(ISZ), .OBUF(OBUF), .OSZ(OSZ), .FD(FD)
  ) dut (
    .clk(clk), .rst(rst), .b8_ai(b8_ai), .b8_we(b8_we), .b8_vi(b8_vi),
    .b8_vo(b8_vo), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_ovf(tx_ovf), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ptr(rx_ptr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_mem [int];
  logic [7:0] m_q [$];
  int         m_init;
  bit         m_ovf;
  int         m_rxp;
  logic [7:0] m_vo;
  bit         m_vo_known;
  bit         m_live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare DUT against the model, advance the model, clock.
  task automatic cycle();
    int a;
    bit pop;
    #1;
    if (m_live) begin
      if (m_vo_known) chk("b8_vo", 32'(b8_vo), 32'(m_vo));
      chk("busy", 32'(busy), 32'(m_init > 0));
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
      chk("tx_data", 32'(tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
      chk("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
      chk("rx_ready", 32'(rx_ready), 32'((m_init == 0) && !b8_we));
      chk("rx_ptr", 32'(rx_ptr), 32'(m_rxp));
    end
    if (rst) begin
      m_init = OSZ; m_q.delete(); m_ovf = 0; m_rxp = TIB;
      m_vo = 8'h00; m_vo_known = 1; m_live = 1;
    end else if (m_live && m_init > 0) begin
      m_mem[OBUF + OSZ - m_init] = 8'h00;
      m_init--;
      m_vo = 8'h00; m_vo_known = 1;
    end else if (m_live) begin
      pop = (m_q.size() > 0) && tx_ready;
      a = int'(b8_ai) & MASK;
      if (!b8_we) begin
        if (m_mem.exists(a)) begin m_vo = m_mem[a]; m_vo_known = 1; end
        else m_vo_known = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (b8_we) begin
        m_mem[a] = b8_vi;
        if (a >= OBUF && a < OBUF + OSZ) begin
          if (m_q.size() < FD) m_q.push_back(b8_vi);
          else m_ovf = 1;
        end
      end else if (rx_valid) begin
        m_mem[m_rxp] = rx_data;
        m_rxp = TIB + ((m_rxp - TIB + 1) % ISZ);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 2 * OSZ; k++) begin
      if (!busy) break;
      n++;
      cycle();
    end
    chk(tag, 32'(n), 32'(OSZ));
  endtask

  initial begin
    rst = 1'b1; b8_ai = '0; b8_we = 1'b0; b8_vi = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    // T1: reset state, INIT length, cleared OBUF
    cycle();
    rst = 1'b0;
    chk("rst_b8_vo", 32'(b8_vo), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ptr", 32'(rx_ptr), 32'(TIB));
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    count_busy("t1_busy_cycles");
    b8_ai = ASZ'(OBUF + 5);
    cycle();
    chk("t1_obuf_clear", 32'(b8_vo), 32'h0);

    // T2: write then read back one cycle later
    b8_we = 1'b1; b8_ai = ASZ'('h200); b8_vi = 8'hA5;
    cycle();
    chk("t2_hold_on_write", 32'(b8_vo), 32'h0);
    b8_we = 1'b0;
    cycle();
    chk("t2_read", 32'(b8_vo), 32'hA5);

    // T3: snooped OBUF writes come out in order
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b8_we = 1'b1; b8_ai = ASZ'(OBUF + i); b8_vi = 8'(8'h41 + i);
      cycle();
    end
    b8_we = 1'b0; b8_ai = ASZ'('h200);
    chk("t3_valid", 32'(tx_valid), 32'h1);
    chk("t3_head", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_pop", 32'(tx_data), 32'(8'h41 + i));
      cycle();
    end
    chk("t3_empty", 32'(tx_valid), 32'h0);

    // T4: FD+1 writes with the host stalled -> overflow, first FD kept
    tx_ready = 1'b0;
    for (int i = 0; i <= FD; i++) begin
      b8_we = 1'b1; b8_ai = ASZ'(OBUF + 16 + i); b8_vi = 8'(8'h80 + i);
      cycle();
    end
    b8_we = 1'b0; b8_ai = ASZ'('h200);
    chk("t4_ovf", 32'(tx_ovf), 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      chk("t4_fifo", 32'(tx_data), 32'(8'h80 + i));
      cycle();
    end
    chk("t4_empty", 32'(tx_valid), 32'h0);
    b8_ai = ASZ'(OBUF + 16 + FD);
    cycle();
    chk("t4_last_in_sram", 32'(b8_vo), 32'(8'h80 + FD));

    // T5: host stream of ISZ+2 bytes wraps the TIB ring
    tx_ready = 1'b0; b8_ai = ASZ'('h200); rx_valid = 1'b1;
    for (int i = 0; i < ISZ + 2; i++) begin
      rx_data = 8'(i);
      cycle();
    end
    rx_valid = 1'b0;
    chk("t5_rx_ptr", 32'(rx_ptr), 32'(TIB + 2));
    b8_ai = ASZ'(TIB);
    cycle();
    chk("t5_tib0", 32'(b8_vo), 32'(ISZ % 256));
    b8_ai = ASZ'(TIB + 1);
    cycle();
    chk("t5_tib1", 32'(b8_vo), 32'((ISZ + 1) % 256));

    // T6: CPU write blocks RX for a cycle
    rx_valid = 1'b1; rx_data = 8'h5A;
    b8_we = 1'b1; b8_ai = ASZ'('h300); b8_vi = 8'h11;
    #1 chk("t6_rx_blocked", 32'(rx_ready), 32'h0);
    cycle();
    chk("t6_ptr_held", 32'(rx_ptr), 32'(TIB + 2));
    b8_we = 1'b0;
    cycle();
    chk("t6_ptr_adv", 32'(rx_ptr), 32'(TIB + 3));
    rx_valid = 1'b0; b8_ai = ASZ'(TIB + 2);
    cycle();
    chk("t6_rx_byte", 32'(b8_vo), 32'h5A);

    // T6: reset mid-INIT restarts the full sweep
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (100) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_busy("t6_busy_restart");

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      case ($urandom % 4)
        0: b8_ai = ASZ'(OBUF + ($urandom % 32));
        1: b8_ai = ASZ'('h200 + ($urandom % 16));
        2: b8_ai = ASZ'(TIB + ($urandom % 16));
        default: b8_ai = ASZ'($urandom & MASK);
      endcase
      b8_we    = (($urandom % 4) == 0);
      b8_vi    = 8'($urandom);
      tx_ready = (($urandom % 3) != 0);
      rx_valid = (($urandom % 3) == 0);
      rx_data  = 8'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
